// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand FIFO: default geometry and pop-count encoding.
package mac_pkg;

  // Default geometry of the operand store.
  localparam int MAC_DATA_WIDTH = 8;
  localparam int MAC_DEPTH      = 4;

  // Number of words removed by one read handshake.
  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_PAIR = 2'd2;

  // Encode how many words a read handshake removes.
  function automatic logic [1:0] pop_sel(input logic pop, input logic single);
    logic [1:0] sel;
    if (!pop) begin
      sel = POP_NONE;
    end else if (single) begin
      sel = POP_ONE;
    end else begin
      sel = POP_PAIR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mac_buf_ram.sv
// Operand register array: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset; the FIFO control never reads an unwritten
// entry while its read data is marked valid.
module mac_buf_ram
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int DEPTH      = MAC_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on an enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Both read ports are pure combinational lookups (show-ahead).
  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
  end

endmodule

// File: rtl/mac_operand_fifo.sv
// Circular operand store feeding the MAC datapath: one-word pushes, pair or
// single-word pops, occupancy tracking and synchronous flush.
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int DEPTH      = MAC_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_single,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q,  count_d;

  logic                  push;
  logic                  pop;
  logic [1:0]            pop_n;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt1;
  logic [DATA_WIDTH-1:0] ram_rdata1;
  logic [DATA_WIDTH-1:0] ram_rdata2;

  // Flow-control decodes; they depend only on the count register so
  // uninitialised memory can never reach them.
  always_comb begin
    full     = (count_q == CNT_WIDTH'(DEPTH));
    empty    = (count_q == {CNT_WIDTH{1'b0}});
    wr_ready = !full;
    count    = count_q;
    if (rd_single) begin
      rd_valid = (count_q >= CNT_WIDTH'(1));
    end else begin
      rd_valid = (count_q >= CNT_WIDTH'(2));
    end
  end

  // Handshake qualification; a push is refused when full even if a pop
  // frees space in the same cycle (no bypass path).
  always_comb begin
    push   = wr_valid && wr_ready;
    pop    = rd_valid && rd_ready;
    pop_n  = pop_sel(pop, rd_single);
    ram_we = push && !flush;
  end

  // Next pointer and occupancy; flush wins over any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {ADDR_WIDTH{1'b0}};
      rd_ptr_d = {ADDR_WIDTH{1'b0}};
      count_d  = {CNT_WIDTH{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case (pop_n)
        POP_ONE:  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        POP_PAIR: rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(2);
        default:  rd_ptr_d = rd_ptr_q;
      endcase
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop_n);
    end
  end

  // State registers, cleared asynchronously; memory contents are left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q <= {ADDR_WIDTH{1'b0}};
      count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Second read index wraps naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_nxt1 = rd_ptr_q + ADDR_WIDTH'(1);
  end

  mac_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (wr_ptr_q),
    .wdata  (wr_data),
    .raddr1 (rd_ptr_q),
    .raddr2 (rd_ptr_nxt1),
    .rdata1 (ram_rdata1),
    .rdata2 (ram_rdata2)
  );

  // Show-ahead read data; the second word is forced to zero in single mode.
  always_comb begin
    data_out1 = ram_rdata1;
    if (rd_single) begin
      data_out2 = {DATA_WIDTH{1'b0}};
    end else begin
      data_out2 = ram_rdata2;
    end
  end

endmodule
